// File: rtl/pga_interface.sv
// Serial write port for a programmable-gain amplifier: shifts an 8-bit gain code MSB-first
// inside a cs_n-low frame, using the system clock as the PGA serial clock.
module pga_interface #(
    parameter int CS_SETUP_CYCLES = 0,
    parameter int CS_HOLD_CYCLES  = 1,
    parameter int IDLE_GAP_CYCLES = 1
) (
    input  logic       sck,
    input  logic       rst,
    input  logic [7:0] code_i,
    input  logic       set_i,
    output logic       ready_o,
    output logic       cs_n,
    output logic       mosi
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP_CYCLES > 0 ? CS_SETUP_CYCLES - 1 : 0);
    localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD_CYCLES  > 0 ? CS_HOLD_CYCLES  - 1 : 0);
    localparam logic [3:0] GAP_LAST   = 4'(IDLE_GAP_CYCLES > 0 ? IDLE_GAP_CYCLES - 1 : 0);

    // Zero-length phases are skipped by resolving the successor state at elaboration.
    localparam logic [2:0] NEXT_AFTER_IDLE  = (CS_SETUP_CYCLES > 0) ? ST_SETUP : ST_SHIFT;
    localparam logic [2:0] NEXT_AFTER_HOLD  = (IDLE_GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
    localparam logic [2:0] NEXT_AFTER_SHIFT = (CS_HOLD_CYCLES > 0) ? ST_HOLD : NEXT_AFTER_HOLD;

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       cs_n_q, cs_n_d;
    logic       mosi_q, mosi_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        cs_n_d    = 1'b1;
        mosi_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (set_i) begin
                    shreg_d   = code_i;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = NEXT_AFTER_IDLE;
                end
            end
            ST_SETUP: begin
                cs_n_d = 1'b0;
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SHIFT: begin
                cs_n_d    = 1'b0;
                mosi_d    = shreg_q[7];
                shreg_d   = {shreg_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    cnt_d   = '0;
                    state_d = NEXT_AFTER_SHIFT;
                end
            end
            ST_HOLD: begin
                cs_n_d = 1'b0;
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = NEXT_AFTER_HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sck) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // Pins change half a cycle after the control logic so they are stable at the PGA's rising-edge sample.
    always_ff @(negedge sck) begin
        if (!rst) begin
            cs_n_q <= 1'b1;
            mosi_q <= 1'b0;
        end else begin
            cs_n_q <= cs_n_d;
            mosi_q <= mosi_d;
        end
    end

    assign ready_o = (state_q == ST_IDLE);
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_pga_interface.sv
// Self-checking bench for pga_interface: a default instance and a swept-parameter instance,
// both compared cycle by cycle against a frame-timing model derived from the S/H/G rules.
module tb_pga_interface;

    logic       sck = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] code0 = 8'h00;
    logic [7:0] code1 = 8'h00;
    logic       set0 = 1'b0;
    logic       set1 = 1'b0;
    logic       ready0, cs_n0, mosi0;
    logic       ready1, cs_n1, mosi1;
    int         checks = 0;
    int         failures = 0;

    always #5 sck = ~sck;

    pga_interface dut0 (
        .sck(sck), .rst(rst), .code_i(code0), .set_i(set0),
        .ready_o(ready0), .cs_n(cs_n0), .mosi(mosi0)
    );

    pga_interface #(
        .CS_SETUP_CYCLES(2), .CS_HOLD_CYCLES(0), .IDLE_GAP_CYCLES(3)
    ) dut1 (
        .sck(sck), .rst(rst), .code_i(code1), .set_i(set1),
        .ready_o(ready1), .cs_n(cs_n1), .mosi(mosi1)
    );

    // Expected pins sampled just after rising edge Rn of a frame accepted at R0.
    // cs_n/mosi seen here are the values the PGA samples at Rn.
    function automatic void expect_at(input int n, input logic [7:0] code, input int s, input int h,
                                      input int g, output logic er, output logic ec, output logic em);
        int k;
        er = (n >= s + 8 + h + g);
        ec = !(n >= 1 && n <= s + 8 + h);
        em = 1'b0;
        if (n >= s + 1 && n <= s + 8) begin
            k  = 7 - (n - s - 1);
            em = code[k[2:0]];
        end
    endfunction

    task automatic drive(input bit sel, input logic s, input logic [7:0] c);
        if (sel) begin
            set1  = s;
            code1 = c;
        end else begin
            set0  = s;
            code0 = c;
        end
    endtask

    // Issues one request and checks every cycle through the point where ready_o returns.
    // Called just after a rising edge with the target instance idle.
    task automatic run_frame(input bit sel, input logic [7:0] code, input int s, input int h, input int g,
                             input int glitch_n, input logic [7:0] glitch_code,
                             input bit keep_set, input logic [7:0] next_code, input string tag);
        int   total;
        logic er, ec, em, r, c, m;
        total = s + 8 + h + g;
        drive(sel, 1'b1, code);
        for (int n = 0; n <= total; n++) begin
            @(posedge sck);
            #1;
            expect_at(n, code, s, h, g, er, ec, em);
            r = sel ? ready1 : ready0;
            c = sel ? cs_n1 : cs_n0;
            m = sel ? mosi1 : mosi0;
            checks += 3;
            if (r !== er) begin
                failures++;
                $display("FAIL %s ready n=%0d got=%b exp=%b", tag, n, r, er);
            end
            if (c !== ec) begin
                failures++;
                $display("FAIL %s cs_n n=%0d got=%b exp=%b", tag, n, c, ec);
            end
            if (m !== em) begin
                failures++;
                $display("FAIL %s mosi n=%0d got=%b exp=%b", tag, n, m, em);
            end
            if (keep_set)
                drive(sel, 1'b1, next_code);
            else if (n == glitch_n - 1)
                drive(sel, 1'b1, glitch_code);
            else
                drive(sel, 1'b0, 8'($urandom));
        end
    endtask

    task automatic test_reset();
        @(posedge sck);
        #1;
        checks += 2;
        if (ready0 !== 1'b1) begin
            failures++;
            $display("FAIL reset ready0 got=%b exp=1", ready0);
        end
        if (ready1 !== 1'b1) begin
            failures++;
            $display("FAIL reset ready1 got=%b exp=1", ready1);
        end
        @(negedge sck);
        #1;
        checks += 4;
        if (cs_n0 !== 1'b1 || cs_n1 !== 1'b1) begin
            failures++;
            $display("FAIL reset cs_n got=%b%b exp=11", cs_n0, cs_n1);
        end
        if (mosi0 !== 1'b0 || mosi1 !== 1'b0) begin
            failures++;
            $display("FAIL reset mosi got=%b%b exp=00", mosi0, mosi1);
        end
        @(posedge sck);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge sck);
            #1;
            checks++;
            if ({ready0, cs_n0, mosi0, ready1, cs_n1, mosi1} !== 6'b110110) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d got=%b exp=110110", i,
                         {ready0, cs_n0, mosi0, ready1, cs_n1, mosi1});
            end
        end
    endtask

    task automatic test_basic();
        run_frame(1'b0, 8'h8F, 0, 1, 1, 0, 8'h00, 1'b0, 8'h00, "basic_8f");
    endtask

    task automatic test_ignored_request();
        run_frame(1'b0, 8'hA5, 0, 1, 1, 3, 8'h00, 1'b0, 8'h00, "ignored_a5");
        for (int i = 0; i < 12; i++) begin
            @(posedge sck);
            #1;
            checks++;
            if ({ready0, cs_n0, mosi0} !== 3'b110) begin
                failures++;
                $display("FAIL ignored_no_second_frame cycle=%0d got=%b exp=110", i, {ready0, cs_n0, mosi0});
            end
        end
    endtask

    task automatic test_back_to_back();
        run_frame(1'b0, 8'h5A, 0, 1, 1, 0, 8'h00, 1'b1, 8'h3C, "b2b_first");
        run_frame(1'b0, 8'h3C, 0, 1, 1, 0, 8'h00, 1'b0, 8'h00, "b2b_second");
        for (int i = 0; i < 3; i++) begin
            @(posedge sck);
            #1;
            checks++;
            if ({ready0, cs_n0, mosi0} !== 3'b110) begin
                failures++;
                $display("FAIL b2b_idle cycle=%0d got=%b exp=110", i, {ready0, cs_n0, mosi0});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic er, ec, em;
        drive(1'b0, 1'b1, 8'hFF);
        for (int n = 0; n <= 3; n++) begin
            @(posedge sck);
            #1;
            if (n == 0)
                drive(1'b0, 1'b0, 8'h00);
            expect_at(n, 8'hFF, 0, 1, 1, er, ec, em);
            checks += 2;
            if (cs_n0 !== ec) begin
                failures++;
                $display("FAIL midrst_pre cs_n n=%0d got=%b exp=%b", n, cs_n0, ec);
            end
            if (mosi0 !== em) begin
                failures++;
                $display("FAIL midrst_pre mosi n=%0d got=%b exp=%b", n, mosi0, em);
            end
        end
        rst = 1'b0;
        @(posedge sck);
        #1;
        checks++;
        if (ready0 !== 1'b1) begin
            failures++;
            $display("FAIL midrst ready got=%b exp=1", ready0);
        end
        @(negedge sck);
        #1;
        checks++;
        if ({cs_n0, mosi0} !== 2'b10) begin
            failures++;
            $display("FAIL midrst pins got=%b exp=10", {cs_n0, mosi0});
        end
        @(posedge sck);
        #1;
        rst = 1'b1;
        run_frame(1'b0, 8'h12, 0, 1, 1, 0, 8'h00, 1'b0, 8'h00, "midrst_recover_12");
    endtask

    task automatic test_param_sweep();
        run_frame(1'b1, 8'h81, 2, 0, 3, 0, 8'h00, 1'b0, 8'h00, "sweep_81");
        for (int i = 0; i < 3; i++) begin
            @(posedge sck);
            #1;
            checks++;
            if ({ready1, cs_n1, mosi1} !== 3'b110) begin
                failures++;
                $display("FAIL sweep_idle cycle=%0d got=%b exp=110", i, {ready1, cs_n1, mosi1});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        logic [7:0] gc;
        int         gn;
        int         idle;
        bit         sel;
        int         total;
        for (int i = 0; i < 12; i++) begin
            sel   = (i % 3 == 2);
            total = sel ? 13 : 10;
            c     = 8'($urandom);
            gc    = 8'($urandom);
            gn    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, total)) : 0;
            run_frame(sel, c, sel ? 2 : 0, sel ? 0 : 1, sel ? 3 : 1, gn, gc, 1'b0, 8'h00, "random");
            idle = int'($urandom_range(0, 3));
            for (int j = 0; j < idle; j++) begin
                @(posedge sck);
                #1;
                checks++;
                if ((sel ? {ready1, cs_n1, mosi1} : {ready0, cs_n0, mosi0}) !== 3'b110) begin
                    failures++;
                    $display("FAIL random_idle frame=%0d cycle=%0d got=%b exp=110", i, j,
                             sel ? {ready1, cs_n1, mosi1} : {ready0, cs_n0, mosi0});
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_ignored_request();
        test_back_to_back();
        test_reset_mid_frame();
        test_param_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
